pixel_clock_divider: RTL and testbench
======================================

Name: pixel_clock_divider

Overview:
- Parametrised successor to the fixed divide-by-2 pixel clock: divides clk50M by a runtime-programmable integer N.
- Produces a square-ish divided clock, clk_out, and a single-cycle clock-enable strobe, ce_pulse, for downstream logic in the clk50M domain (VGA timing, pong game tick).
- Divisor changes are glitch-free: a new divisor takes effect only at a period boundary.

Parameters:
- WIDTH, 8, width of the divisor and the phase counter.
- DIV_RESET, 2, divisor active after reset. Legal range 1..2^WIDTH-1. The default reproduces 50MHz -> 25MHz.

Ports:
- clk50M  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  when low, the phase counter and clk_out hold their values.
- restart  input  1  synchronous phase restart; the next enabled edge begins a new period at phase 0.
- div_load  input  1  one-cycle request to load div_value.
- div_value  input  WIDTH  requested divisor N.
- clk_out  output  1  divided clock (registered).
- ce_pulse  output  1  high for one clk50M cycle at phase 0 of each period.
- div_active  output  WIDTH  divisor currently in effect.
- pending_valid  output  1  a loaded divisor is waiting for the next period boundary.
- div_err  output  1  one-cycle pulse when div_load carries div_value==0.

Behaviour:
- Reset (async, immediate):
  - clk_out=0, ce_pulse=0, div_err=0, pending_valid=0.
  - div_active=DIV_RESET, phase p=DIV_RESET-1, pending=DIV_RESET.
  - Because p starts at DIV_RESET-1, the first enabled edge after reset wraps to p=0.
- Enabled edge (enable=1): let N=div_active and H=N-floor(N/2), i.e. ceil(N/2).
  - p_next = 0 if p==N-1 or restart=1; otherwise p_next = p+1.
  - clk_out <= (p_next < H).
  - ce_pulse <= (p_next == 0).
  - Result: N=2 gives 1,0,1,0; N=5 gives high 3 cycles, low 2.
- N=1:
  - p_next is always 0.
  - ce_pulse is high every enabled cycle.
  - clk_out is held at 1.
- enable=0:
  - p and clk_out hold their values.
  - ce_pulse <= 0.
  - restart is ignored.
  - div_load is still accepted.
- Divisor load:
  - div_load=1 with div_value>=1: pending <= div_value, pending_valid <= 1.
  - div_load=1 with div_value==0: div_err <= 1 for one cycle; pending and pending_valid are unchanged.
  - div_err is 0 in every other cycle.
- Apply at boundary:
  - On an enabled edge where p_next==0 (wrap or restart) and pending_valid=1: div_active <= pending, pending_valid <= 0.
  - The new period's clk_out and ce_pulse use the new N, computed with p_next=0, so clk_out is 1 (or 1 for N=1).
- Simultaneous div_load and boundary:
  - A valid div_value presented in the boundary cycle bypasses pending and becomes div_active at that boundary.
  - pending_valid ends 0.
  - An older pending value is discarded.
- Back-to-back loads before a boundary: the last valid one wins.
- restart and wrap in the same cycle are equivalent: p_next=0.
- Reset mid-period: all state returns to reset values at once, including a pending divisor, which is lost.
- Latency:
  - ce_pulse and clk_out are registered and both rise on the same edge.
  - No combinational path from any input to any output.
- Width: the counter compares against N-1 in WIDTH bits; N=2^WIDTH-1 must work without overflow.

Test Plan:
- Reset released, enable=1, default N=2 -> clk_out 1,0,1,0… from the first edge; ce_pulse high on alternate cycles coincident with clk_out rising; div_active=2.
- Mid-period div_load with div_value=5 -> pending_valid=1 until the next wrap; from then on clk_out runs 3 high / 2 low and ce_pulse comes every 5 cycles; no runt pulse in the old period.
- div_load with div_value=0 -> div_err is a single-cycle pulse; div_active and pending_valid are unchanged; output pattern is unaffected.
- N=3, enable low for 4 cycles mid-period -> clk_out frozen, ce_pulse=0, phase resumes where it stopped. Then restart=1 at p=1 -> next edge p=0, ce_pulse=1, clk_out=1.
- div_load of 4 exactly on the wrap cycle of N=2, with pending=7 outstanding -> div_active=4 immediately; the 7 is discarded; pending_valid=0.
- Assert reset asynchronously mid-high phase with N=6 and a pending load -> clk_out=0 at once; div_active=DIV_RESET; pending_valid=0; the first post-reset edge gives ce_pulse=1.

Source files
------------

// File: rtl/pixel_clock_divider_if.sv
// Control and status bundle for pixel_clock_divider: run/restart/divisor-load controls in, divided clock and status out.
interface pixel_clock_divider_if #(
   parameter int WIDTH = 8
);
   logic             enable;
   logic             restart;
   logic             div_load;
   logic [WIDTH-1:0] div_value;
   logic             clk_out;
   logic             ce_pulse;
   logic [WIDTH-1:0] div_active;
   logic             pending_valid;
   logic             div_err;

   modport master (
      output enable, restart, div_load, div_value,
      input  clk_out, ce_pulse, div_active, pending_valid, div_err
   );

   modport slave (
      input  enable, restart, div_load, div_value,
      output clk_out, ce_pulse, div_active, pending_valid, div_err
   );
endinterface

// File: rtl/pixel_clock_divider.sv
// Divides clk50M by a runtime divisor N: registered clk_out (ceil(N/2) high) and a phase-0 ce_pulse.
// All outputs are registered. A new divisor waits in a pending slot until the next period boundary.
module pixel_clock_divider #(
   parameter int WIDTH     = 8,
   parameter int DIV_RESET = 2
) (
   input  logic                  clk50M,
   input  logic                  reset,
   pixel_clock_divider_if.slave  bus
);
   localparam logic [WIDTH-1:0] DIV_INIT   = WIDTH'(DIV_RESET);
   localparam logic [WIDTH-1:0] PHASE_INIT = WIDTH'(DIV_RESET - 1);
   localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

   logic [WIDTH-1:0] phase;
   logic [WIDTH-1:0] active;
   logic [WIDTH-1:0] pending;
   logic             pend_vld;
   logic             clk_q;
   logic             ce_q;
   logic             err_q;

   logic             load_ok;
   logic             load_zero;
   logic             last_phase;
   logic [WIDTH-1:0] phase_nxt;
   logic             boundary;
   logic [WIDTH-1:0] n_nxt;
   logic [WIDTH-1:0] half;
   logic             clk_nxt;

   always_comb begin
      load_ok    = bus.div_load && (bus.div_value != '0);
      load_zero  = bus.div_load && (bus.div_value == '0);
      // active is never 0, so active-1 stays within WIDTH bits even at 2^WIDTH-1
      last_phase = (phase == (active - ONE));
      phase_nxt  = (last_phase || bus.restart) ? '0 : (phase + ONE);
      boundary   = bus.enable && (phase_nxt == '0);

      // A divisor loaded in the boundary cycle takes priority over an older pending one
      n_nxt = active;
      if (boundary) begin
         if (load_ok) begin
            n_nxt = bus.div_value;
         end else if (pend_vld) begin
            n_nxt = pending;
         end
      end

      half    = n_nxt - (n_nxt >> 1);
      clk_nxt = (phase_nxt < half);
   end

   always_ff @(posedge clk50M or posedge reset) begin
      if (reset) begin
         phase    <= PHASE_INIT;
         active   <= DIV_INIT;
         pending  <= DIV_INIT;
         pend_vld <= 1'b0;
         clk_q    <= 1'b0;
         ce_q     <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         err_q <= load_zero;
         ce_q  <= boundary;

         if (bus.enable) begin
            phase <= phase_nxt;
            clk_q <= clk_nxt;
         end

         if (load_ok) begin
            pending <= bus.div_value;
         end

         if (boundary) begin
            active   <= n_nxt;
            pend_vld <= 1'b0;
         end else if (load_ok) begin
            pend_vld <= 1'b1;
         end
      end
   end

   assign bus.clk_out       = clk_q;
   assign bus.ce_pulse      = ce_q;
   assign bus.div_active    = active;
   assign bus.pending_valid = pend_vld;
   assign bus.div_err       = err_q;
endmodule

// File: tb/tb_pixel_clock_divider.sv
// Directed vectors for pixel_clock_divider; expected outputs are queued per cycle and checked by a separate monitor.
module tb_pixel_clock_divider;
   localparam int WIDTH = 8;

   logic clk50M = 1'b0;
   logic reset;

   always #5 clk50M = ~clk50M;

   pixel_clock_divider_if #(.WIDTH(WIDTH)) bus ();

   pixel_clock_divider #(.WIDTH(WIDTH), .DIV_RESET(2)) dut (
      .clk50M (clk50M),
      .reset  (reset),
      .bus    (bus)
   );

   typedef struct packed {
      logic             clk_out;
      logic             ce_pulse;
      logic [WIDTH-1:0] div_active;
      logic             pending_valid;
      logic             div_err;
   } obs_t;

   typedef struct {
      int   id;
      obs_t want;
   } exp_t;

   exp_t exp_q[$];
   int   total  = 0;
   int   bad    = 0;
   int   vec_id = 0;

   function automatic obs_t sample();
      obs_t o;
      o.clk_out       = bus.clk_out;
      o.ce_pulse      = bus.ce_pulse;
      o.div_active    = bus.div_active;
      o.pending_valid = bus.pending_valid;
      o.div_err       = bus.div_err;
      return o;
   endfunction

   function automatic obs_t mk(int c, int ce, int act, int pv, int err);
      obs_t o;
      o.clk_out       = c[0];
      o.ce_pulse      = ce[0];
      o.div_active    = act[WIDTH-1:0];
      o.pending_valid = pv[0];
      o.div_err       = err[0];
      return o;
   endfunction

   task automatic check(input string name, input int id, input obs_t got, input obs_t want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s #%0d got clk=%b ce=%b act=%0d pv=%b err=%b want clk=%b ce=%b act=%0d pv=%b err=%b",
                  name, id, got.clk_out, got.ce_pulse, got.div_active, got.pending_valid, got.div_err,
                  want.clk_out, want.ce_pulse, want.div_active, want.pending_valid, want.div_err);
      end
   endtask

   // Drive one cycle of inputs at the falling edge and queue what the next rising edge must produce
   task automatic step(input int en, input int rs, input int ld, input int val,
                       input int c, input int ce, input int act, input int pv, input int err);
      exp_t e;
      @(negedge clk50M);
      bus.enable    = en[0];
      bus.restart   = rs[0];
      bus.div_load  = ld[0];
      bus.div_value = val[WIDTH-1:0];
      vec_id++;
      e.id   = vec_id;
      e.want = mk(c, ce, act, pv, err);
      exp_q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk50M);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cycle", e.id, sample(), e.want);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      bus.enable    = 1'b0;
      bus.restart   = 1'b0;
      bus.div_load  = 1'b0;
      bus.div_value = '0;
      reset = 1'b0;
      #1 reset = 1'b1;
      #2 check("reset_state", 0, sample(), mk(0, 0, 2, 0, 0));
      @(posedge clk50M);
      #1 check("reset_hold", 0, sample(), mk(0, 0, 2, 0, 0));
      @(negedge clk50M);
      reset = 1'b0;

      // Default N=2 from the first enabled edge
      step(1,0,0,0, 1,1,2,0,0);
      step(1,0,0,0, 0,0,2,0,0);
      step(1,0,0,0, 1,1,2,0,0);
      step(1,0,0,0, 0,0,2,0,0);
      step(1,0,0,0, 1,1,2,0,0);
      // Mid-period load of 5, applied at the wrap
      step(1,0,1,5, 0,0,2,1,0);
      step(1,0,0,0, 1,1,5,0,0);
      step(1,0,0,0, 1,0,5,0,0);
      step(1,0,0,0, 1,0,5,0,0);
      step(1,0,0,0, 0,0,5,0,0);
      step(1,0,0,0, 0,0,5,0,0);
      step(1,0,0,0, 1,1,5,0,0);
      step(1,0,0,0, 1,0,5,0,0);
      // Zero divisor: single-cycle error, pattern undisturbed
      step(1,0,1,0, 1,0,5,0,1);
      step(1,0,0,0, 0,0,5,0,0);
      step(1,0,0,0, 0,0,5,0,0);
      step(1,0,0,0, 1,1,5,0,0);
      // Back-to-back loads 7 then 3, plus a zero load while pending; 3 must win
      step(1,0,1,7, 1,0,5,1,0);
      step(1,0,1,3, 1,0,5,1,0);
      step(1,0,1,0, 0,0,5,1,1);
      step(1,0,0,0, 0,0,5,1,0);
      step(1,0,0,0, 1,1,3,0,0);
      step(1,0,0,0, 1,0,3,0,0);
      // Freeze for 4 cycles mid-period; restart while frozen is ignored
      step(0,0,0,0, 1,0,3,0,0);
      step(0,1,0,0, 1,0,3,0,0);
      step(0,0,0,0, 1,0,3,0,0);
      step(0,0,0,0, 1,0,3,0,0);
      step(1,0,0,0, 0,0,3,0,0);
      step(1,0,0,0, 1,1,3,0,0);
      step(1,0,0,0, 1,0,3,0,0);
      // Restart at phase 1
      step(1,1,0,0, 1,1,3,0,0);
      step(1,0,0,0, 1,0,3,0,0);
      step(1,0,0,0, 0,0,3,0,0);
      step(1,0,0,0, 1,1,3,0,0);
      // Back to N=2, then pending 7 overridden by 4 loaded on the wrap cycle
      step(1,0,1,2, 1,0,3,1,0);
      step(1,0,0,0, 0,0,3,1,0);
      step(1,0,0,0, 1,1,2,0,0);
      step(1,0,1,7, 0,0,2,1,0);
      step(1,0,1,4, 1,1,4,0,0);
      step(1,0,0,0, 1,0,4,0,0);
      step(1,0,0,0, 0,0,4,0,0);
      step(1,0,0,0, 0,0,4,0,0);
      step(1,0,0,0, 1,1,4,0,0);
      step(1,0,0,0, 1,0,4,0,0);
      // N=6, then a pending 9 lost to an async reset in the high phase
      step(1,0,1,6, 0,0,4,1,0);
      step(1,0,0,0, 0,0,4,1,0);
      step(1,0,0,0, 1,1,6,0,0);
      step(1,0,0,0, 1,0,6,0,0);
      step(1,0,1,9, 1,0,6,1,0);
      @(posedge clk50M);
      #3 reset = 1'b1;
      #1 check("async_reset", 0, sample(), mk(0, 0, 2, 0, 0));
      @(negedge clk50M);
      bus.enable   = 1'b0;
      bus.div_load = 1'b0;
      reset = 1'b0;
      step(1,0,0,0, 1,1,2,0,0);
      step(1,0,0,0, 0,0,2,0,0);
      step(1,0,0,0, 1,1,2,0,0);
      // N=1: strobe every cycle, clk_out held high
      step(1,0,1,1, 0,0,2,1,0);
      step(1,0,0,0, 1,1,1,0,0);
      step(1,0,0,0, 1,1,1,0,0);
      step(1,0,0,0, 1,1,1,0,0);
      // Largest divisor 255: 128 high, 127 low
      step(1,0,1,255, 1,1,255,0,0);
      for (int k = 1; k <= 256; k++) begin
         int p;
         p = k % 255;
         step(1,0,0,0, (p < 128) ? 1 : 0, (p == 0) ? 1 : 0, 255, 0, 0);
      end

      repeat (3) @(posedge clk50M);
      #2;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain got %0d unchecked entries want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
